// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the 5-stage MIPS pipe.
// Optional stall counters are built when HAZARD_PERF_EN is defined.
module hazard_unit #(
   parameter int RegAddrWidth  = 5,
   parameter int WriteRegWidth = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [RegAddrWidth-1:0]  A1,
   input  logic [RegAddrWidth-1:0]  A2,
   input  logic [RegAddrWidth-1:0]  RsE,
   input  logic [RegAddrWidth-1:0]  RtE,
   input  logic [WriteRegWidth-1:0] WriteRegE,
   input  logic [WriteRegWidth-1:0] WriteRegM,
   input  logic [WriteRegWidth-1:0] WriteRegW,
   input  logic                     RegWriteD,
   input  logic                     MemToRegD,
   input  logic                     BranchD,
   output logic                     RegWriteW,
   output logic                     MemToRegW,
   output logic                     StallF,
   output logic                     StallD,
   output logic                     FlushE,
   output logic                     ForwardAD,
   output logic                     ForwardBD,
`ifdef HAZARD_PERF_EN
   output logic [15:0]              LwStallCnt,
   output logic [15:0]              BrStallCnt,
`endif
   output logic [1:0]               ForwardAE,
   output logic [1:0]               ForwardBE
);

   logic r_regwrite_e;
   logic r_memtoreg_e;
   logic r_regwrite_m;
   logic r_memtoreg_m;
   logic r_regwrite_w;
   logic r_memtoreg_w;

   logic [RegAddrWidth-1:0] w_wre;
   logic [RegAddrWidth-1:0] w_wrm;
   logic [RegAddrWidth-1:0] w_wrw;
   logic                    w_unused;
   logic                    w_lwstall;
   logic                    w_brstall;
   logic                    w_stall;
   logic                    w_flush;
   logic [1:0]              w_fae;
   logic [1:0]              w_fbe;
   logic                    w_fad;
   logic                    w_fbd;

   // Only the register-file index bits of the destination taps matter.
   assign w_wre = WriteRegE[RegAddrWidth-1:0];
   assign w_wrm = WriteRegM[RegAddrWidth-1:0];
   assign w_wrw = WriteRegW[RegAddrWidth-1:0];
   assign w_unused = ^{WriteRegE[WriteRegWidth-1:RegAddrWidth],
                       WriteRegM[WriteRegWidth-1:RegAddrWidth],
                       WriteRegW[WriteRegWidth-1:RegAddrWidth]};

   // Hazard detection and forwarding selects from taps and control state.
   always_comb begin
      w_lwstall = r_memtoreg_e && ((RtE == A1) || (RtE == A2));
      w_brstall = BranchD &&
                  ((r_regwrite_e && ((w_wre == A1) || (w_wre == A2))) ||
                   (r_memtoreg_m && ((w_wrm == A1) || (w_wrm == A2))));
      w_stall   = w_lwstall || w_brstall;
      w_flush   = w_stall && !reset;

      w_fae = 2'b00;
      if ((RsE != '0) && (RsE == w_wrm) && r_regwrite_m)
         w_fae = 2'b10;
      else if ((RsE != '0) && (RsE == w_wrw) && r_regwrite_w)
         w_fae = 2'b01;

      w_fbe = 2'b00;
      if ((RtE != '0) && (RtE == w_wrm) && r_regwrite_m)
         w_fbe = 2'b10;
      else if ((RtE != '0) && (RtE == w_wrw) && r_regwrite_w)
         w_fbe = 2'b01;

      w_fad = (A1 != '0) && (A1 == w_wrm) && r_regwrite_m;
      w_fbd = (A2 != '0) && (A2 == w_wrm) && r_regwrite_m;
   end

   // Reset forces every output low, even before the first clock edge.
   assign StallF    = w_flush;
   assign StallD    = w_flush;
   assign FlushE    = w_flush;
   assign ForwardAE = reset ? 2'b00 : w_fae;
   assign ForwardBE = reset ? 2'b00 : w_fbe;
   assign ForwardAD = w_fad && !reset;
   assign ForwardBD = w_fbd && !reset;
   assign RegWriteW = r_regwrite_w && !reset;
   assign MemToRegW = r_memtoreg_w && !reset;

   // Control pipeline E/M/W; a flush turns the D->E capture into a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_regwrite_e <= 1'b0;
         r_memtoreg_e <= 1'b0;
         r_regwrite_m <= 1'b0;
         r_memtoreg_m <= 1'b0;
         r_regwrite_w <= 1'b0;
         r_memtoreg_w <= 1'b0;
      end else begin
         r_regwrite_e <= w_flush ? 1'b0 : RegWriteD;
         r_memtoreg_e <= w_flush ? 1'b0 : MemToRegD;
         r_regwrite_m <= r_regwrite_e;
         r_memtoreg_m <= r_memtoreg_e;
         r_regwrite_w <= r_regwrite_m;
         r_memtoreg_w <= r_memtoreg_m;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [15:0] r_lw_cnt;
   logic [15:0] r_br_cnt;

   // Saturating counters of cycles spent in each stall type.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lw_cnt <= 16'd0;
         r_br_cnt <= 16'd0;
      end else begin
         if (w_lwstall && (r_lw_cnt != 16'hFFFF))
            r_lw_cnt <= r_lw_cnt + 16'd1;
         if (w_brstall && (r_br_cnt != 16'hFFFF))
            r_br_cnt <= r_br_cnt + 16'd1;
      end
   end

   assign LwStallCnt = reset ? 16'd0 : r_lw_cnt;
   assign BrStallCnt = reset ? 16'd0 : r_br_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit.
// Counter checks are compiled only when HAZARD_PERF_EN is defined.
module tb_hazard_unit;

   logic       clk;
   logic       reset;
   logic [4:0] A1, A2, RsE, RtE;
   logic [5:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteD, MemToRegD, BranchD;
   logic       RegWriteW, MemToRegW;
   logic       StallF, StallD, FlushE;
   logic       ForwardAD, ForwardBD;
   logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
   logic [15:0] LwStallCnt, BrStallCnt;
`endif

   int checks;
   int errors;

   hazard_unit #(.RegAddrWidth(5), .WriteRegWidth(6)) dut (
      .clk(clk), .reset(reset),
      .A1(A1), .A2(A2), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
      .WriteRegW(WriteRegW),
      .RegWriteD(RegWriteD), .MemToRegD(MemToRegD),
      .BranchD(BranchD),
      .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
      .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
`ifdef HAZARD_PERF_EN
      .LwStallCnt(LwStallCnt), .BrStallCnt(BrStallCnt),
`endif
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr;
      A1 = 0; A2 = 0; RsE = 0; RtE = 0;
      WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      RegWriteD = 0; MemToRegD = 0; BranchD = 0;
   endtask

   task automatic clean;
      clr();
      tick(); tick(); tick(); tick();
   endtask

   function automatic logic [10:0] allout();
      return {RegWriteW, MemToRegW, StallF, StallD, FlushE,
              ForwardAD, ForwardBD, ForwardAE, ForwardBE};
   endfunction

   task automatic test_reset;
      reset = 1;
      clr();
      MemToRegD = 1; RegWriteD = 1; BranchD = 1;
      A1 = 5; A2 = 5; RsE = 5; RtE = 5;
      WriteRegE = 5; WriteRegM = 5; WriteRegW = 5;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (allout() !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold%0d: got %b want 0", i, allout());
         end
         if (i < 2) tick();
      end
      reset = 0;
      #1;
      checks++;
      if (allout() !== 11'd0) begin
         errors++;
         $display("FAIL reset_release: got %b want 0", allout());
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (LwStallCnt !== 16'd0 || BrStallCnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %h/%h want 0/0",
                  LwStallCnt, BrStallCnt);
      end
`endif
      clean();
   endtask

   task automatic test_alu_chain;
      RegWriteD = 1;
      tick();
      RegWriteD = 0;
      tick();
      WriteRegM = 3; WriteRegE = 3; RsE = 3; RtE = 3;
      #1;
      checks++;
      if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
         errors++;
         $display("FAIL alu_fwd_m: got %b/%b want 10/10",
                  ForwardAE, ForwardBE);
      end
      WriteRegM = 6'h23;
      #1;
      checks++;
      if (ForwardAE !== 2'b10) begin
         errors++;
         $display("FAIL alu_upper_bits: got %b want 10", ForwardAE);
      end
      RsE = 0; WriteRegM = 0;
      #1;
      checks++;
      if (ForwardAE !== 2'b00) begin
         errors++;
         $display("FAIL alu_reg0: got %b want 00", ForwardAE);
      end
      RsE = 3; WriteRegM = 3;
      tick();
      WriteRegW = 3;
      #1;
      checks++;
      if (ForwardAE !== 2'b01 || RegWriteW !== 1'b1) begin
         errors++;
         $display("FAIL alu_fwd_w: got %b rw=%b want 01 rw=1",
                  ForwardAE, RegWriteW);
      end
      clean();
   endtask

   task automatic test_back_to_back;
      RegWriteD = 1;
      tick();
      tick();
      RegWriteD = 0;
      tick();
      WriteRegM = 4; WriteRegW = 4; RsE = 4; RtE = 6;
      #1;
      checks++;
      if (ForwardAE !== 2'b10 || ForwardBE !== 2'b00) begin
         errors++;
         $display("FAIL b2b_prio: got %b/%b want 10/00",
                  ForwardAE, ForwardBE);
      end
      WriteRegM = 8; WriteRegW = 6;
      #1;
      checks++;
      if (ForwardAE !== 2'b00 || ForwardBE !== 2'b01) begin
         errors++;
         $display("FAIL b2b_w_only: got %b/%b want 00/01",
                  ForwardAE, ForwardBE);
      end
      clean();
   endtask

   task automatic test_load_use;
      RegWriteD = 1; MemToRegD = 1;
      tick();
      MemToRegD = 0;
      RtE = 5; A1 = 5; WriteRegE = 5;
      #1;
      checks++;
      if ({StallF, StallD, FlushE} !== 3'b111) begin
         errors++;
         $display("FAIL lw_stall: got %b want 111",
                  {StallF, StallD, FlushE});
      end
      tick();
      WriteRegM = 5; WriteRegE = 0;
      #1;
      checks++;
      if ({StallF, StallD, FlushE} !== 3'b000) begin
         errors++;
         $display("FAIL lw_release: got %b want 000",
                  {StallF, StallD, FlushE});
      end
      RegWriteD = 0;
      tick();
      RsE = 5; RtE = 0; WriteRegM = 0; WriteRegW = 5;
      #1;
      checks++;
      if (ForwardAE !== 2'b01 || MemToRegW !== 1'b1) begin
         errors++;
         $display("FAIL lw_fwd_w: got %b m2r=%b want 01 m2r=1",
                  ForwardAE, MemToRegW);
      end
      clean();
   endtask

   task automatic test_branch_load;
      int n;
      RegWriteD = 1; MemToRegD = 1;
      tick();
      RegWriteD = 0; MemToRegD = 0;
      BranchD = 1; A1 = 7; RtE = 7; WriteRegE = 7;
      n = 0;
      #1;
      if (StallF === 1'b1) n++;
      tick();
      RtE = 0; WriteRegE = 0; WriteRegM = 7;
      #1;
      if (StallF === 1'b1 && FlushE === 1'b1) n++;
      tick();
      WriteRegM = 0; WriteRegW = 7;
      #1;
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL brld_stalls: got %0d want 2", n);
      end
      checks++;
      if (StallF !== 1'b0 || ForwardAD !== 1'b0) begin
         errors++;
         $display("FAIL brld_after: got st=%b fad=%b want 0/0",
                  StallF, ForwardAD);
      end
      clean();
   endtask

   task automatic test_branch_alu;
      RegWriteD = 1;
      tick();
      RegWriteD = 0;
      BranchD = 1; A1 = 9; A2 = 2; WriteRegE = 9;
      #1;
      checks++;
      if ({StallF, StallD, FlushE} !== 3'b111) begin
         errors++;
         $display("FAIL bralu_stall: got %b want 111",
                  {StallF, StallD, FlushE});
      end
      tick();
      WriteRegE = 0; WriteRegM = 9;
      #1;
      checks++;
      if (StallF !== 1'b0 || ForwardAD !== 1'b1 || ForwardBD !== 1'b0)
      begin
         errors++;
         $display("FAIL bralu_fwd: got st=%b fad=%b fbd=%b want 0/1/0",
                  StallF, ForwardAD, ForwardBD);
      end
      A2 = 9; A1 = 0;
      #1;
      checks++;
      if (ForwardBD !== 1'b1 || ForwardAD !== 1'b0) begin
         errors++;
         $display("FAIL bralu_fbd: got fad=%b fbd=%b want 0/1",
                  ForwardAD, ForwardBD);
      end
      clean();
   endtask

   task automatic test_reset_mid_stall;
      RegWriteD = 1; MemToRegD = 1;
      tick();
      RegWriteD = 0; MemToRegD = 0;
      RtE = 5; A1 = 5;
      reset = 1;
      #1;
      checks++;
      if ({StallF, StallD, FlushE} !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid: got %b want 000",
                  {StallF, StallD, FlushE});
      end
      tick();
      reset = 0;
      tick();
      tick();
      #1;
      checks++;
      if (StallF !== 1'b0 || RegWriteW !== 1'b0 || MemToRegW !== 1'b0)
      begin
         errors++;
         $display("FAIL rst_discard: got st=%b rw=%b m2r=%b want 0",
                  StallF, RegWriteW, MemToRegW);
      end
      clean();
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf;
      reset = 1;
      clr();
      tick();
      reset = 0;
      for (int i = 0; i < 3; i++) begin
         RegWriteD = 1; MemToRegD = 1;
         tick();
         RegWriteD = 0; MemToRegD = 0;
         RtE = 5; A1 = 5;
         tick();
         clr();
         tick(); tick();
      end
      for (int i = 0; i < 2; i++) begin
         RegWriteD = 1;
         tick();
         RegWriteD = 0;
         BranchD = 1; A1 = 9; WriteRegE = 9;
         tick();
         clr();
         tick(); tick();
      end
      checks++;
      if (LwStallCnt !== 16'd3 || BrStallCnt !== 16'd2) begin
         errors++;
         $display("FAIL perf_cnt: got %0d/%0d want 3/2",
                  LwStallCnt, BrStallCnt);
      end
      force dut.r_lw_cnt = 16'hFFFE;
      #1;
      release dut.r_lw_cnt;
      for (int i = 0; i < 3; i++) begin
         RegWriteD = 1; MemToRegD = 1;
         tick();
         RegWriteD = 0; MemToRegD = 0;
         RtE = 5; A1 = 5;
         tick();
         clr();
         tick();
      end
      checks++;
      if (LwStallCnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL perf_sat: got %h want ffff", LwStallCnt);
      end
      clean();
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_alu_chain();
      test_back_to_back();
      test_load_use();
      test_branch_load();
      test_branch_alu();
      test_reset_mid_stall();
`ifdef HAZARD_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
